// File: rtl/instr_fetch_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_seq_pkg
// Purpose  : Shared sequencer/datapath definitions: state encodings, opcodes
//            and a small opcode-extraction helper.
// Contents : state_t  - sequencer state codes seen by the datapath
//            OP_*     - opcode byte values (instruction bits [31:24])
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_seq_pkg;

    // STATE_EXEC keeps its established code; the fetch states use the
    // free codes below it so the datapath decode is unaffected.
    typedef enum logic [3:0] {
        STATE_HLT      = 4'd0,
        STATE_FETCH0   = 4'd1,
        STATE_FETCH0_W = 4'd2,
        STATE_FETCH1   = 4'd3,
        STATE_FETCH1_W = 4'd4,
        STATE_EXEC     = 4'd5
    } state_t;

    localparam logic [7:0] OP_CP     = 8'h01;
    localparam logic [7:0] OP_LIMM32 = 8'h20;
    localparam logic [7:0] OP_END    = 8'hFF;

    function automatic logic [7:0] opcode_of(input logic [31:0] word);
        return word[31:24];
    endfunction

endpackage : instr_fetch_seq_pkg
`default_nettype wire

// File: rtl/instr_fetch_seq_pc_counter.sv
`default_nettype none
// ============================================================================
// Module   : pc_counter
// Purpose  : Program counter register with load and wrapping increment.
// Ports    : clk, reset       - clock / async active-high reset
//            load_i           - load load_val_i (has priority over increment)
//            load_val_i       - value to load
//            inc_i            - advance by one, wrapping modulo 2^PMEM_AW
//            pc_o             - current program counter
// Revision : 1.0 - initial release
// ============================================================================
module pc_counter #(
    parameter int unsigned          PMEM_AW  = 10,
    parameter logic [PMEM_AW-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [PMEM_AW-1:0]  load_val_i,
    input  logic                inc_i,
    output logic [PMEM_AW-1:0]  pc_o
);

    logic [PMEM_AW-1:0] pc_q;
    logic [PMEM_AW-1:0] pc_d;

    // Increment wraps naturally through the PMEM_AW-bit truncation.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule : pc_counter
`default_nettype wire

// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_seq
// Purpose  : Instruction sequencer ahead of the execute datapath. Owns the PC
//            and program-memory read port, assembles one- or two-word
//            instructions and presents them for exactly one EXEC cycle.
// Ports    : clk, reset        - clock / async active-high reset
//            start_i           - pulse: leave HLT and fetch from RESET_PC
//            pmem_addr_o       - program-memory word address
//            pmem_rdata_i      - read data, valid one cycle after address
//            jmp_req_i/addr_i  - branch request, honoured only in EXEC
//            instr0_o/instr1_o - assembled instruction words
//            current_state_o   - sequencer state for the datapath
//            pc_o              - next word address to fetch
//            halted_o          - high while halted
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_seq
    import instr_fetch_seq_pkg::*;
#(
    parameter int unsigned          PMEM_AW  = 10,
    parameter logic [PMEM_AW-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    output logic [PMEM_AW-1:0]  pmem_addr_o,
    input  logic [31:0]         pmem_rdata_i,
    input  logic                jmp_req_i,
    input  logic [PMEM_AW-1:0]  jmp_addr_i,
    output logic [31:0]         instr0_o,
    output logic [31:0]         instr1_o,
    output logic [3:0]          current_state_o,
    output logic [PMEM_AW-1:0]  pc_o,
    output logic                halted_o
);

    state_t             state_q;
    logic [31:0]        instr0_q;
    logic [31:0]        instr1_q;
    logic [PMEM_AW-1:0] pc;
    logic               pc_load;
    logic               pc_inc;
    logic [PMEM_AW-1:0] pc_load_val;
    logic [7:0]         rdata_op;

    assign rdata_op = opcode_of(pmem_rdata_i);

    // PC control. The PC advances once per consumed word, including the
    // END word, so after END it points just past the terminator.
    always_comb begin
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load_val = RESET_PC;
        case (state_q)
            STATE_HLT: begin
                pc_load = start_i;
            end
            STATE_EXEC: begin
                pc_load     = jmp_req_i;
                pc_load_val = jmp_addr_i;
            end
            STATE_FETCH0_W, STATE_FETCH1_W: begin
                pc_inc = 1'b1;
            end
            default: begin
            end
        endcase
    end

    pc_counter #(
        .PMEM_AW  (PMEM_AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    // The memory address always equals the PC, so the PC register doubles
    // as the registered address output.
    assign pmem_addr_o = pc;
    assign pc_o        = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STATE_HLT;
            instr0_q <= '0;
            instr1_q <= '0;
        end else begin
            case (state_q)
                STATE_HLT: begin
                    if (start_i) begin
                        state_q <= STATE_FETCH0;
                    end
                end
                STATE_FETCH0: begin
                    state_q <= STATE_FETCH0_W;
                end
                STATE_FETCH0_W: begin
                    instr0_q <= pmem_rdata_i;
                    if (rdata_op == OP_LIMM32) begin
                        state_q <= STATE_FETCH1;
                    end else if (rdata_op == OP_END) begin
                        state_q <= STATE_HLT;
                    end else begin
                        instr1_q <= '0;
                        state_q  <= STATE_EXEC;
                    end
                end
                STATE_FETCH1: begin
                    state_q <= STATE_FETCH1_W;
                end
                STATE_FETCH1_W: begin
                    instr1_q <= pmem_rdata_i;
                    state_q  <= STATE_EXEC;
                end
                STATE_EXEC: begin
                    state_q <= STATE_FETCH0;
                end
                default: begin
                    state_q <= STATE_HLT;
                end
            endcase
        end
    end

    assign instr0_o        = instr0_q;
    assign instr1_o        = instr1_q;
    assign current_state_o = state_q;
    assign halted_o        = (state_q == STATE_HLT);

endmodule : instr_fetch_seq
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_seq
// Purpose  : Self-checking bench for instr_fetch_seq. Instance A uses the
//            default 10-bit address; instance B uses a 4-bit address with
//            RESET_PC=15 to exercise PC wrap. Expected EXEC-cycle contents
//            are queued when a program is started and popped by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_seq;
    import instr_fetch_seq_pkg::*;

    localparam logic [31:0] CPW    = {OP_CP, 24'h041000};
    localparam logic [31:0] LIMMW  = {OP_LIMM32, 6'd3, 18'd0};
    localparam logic [31:0] ENDW   = {OP_END, 24'd0};
    localparam logic [31:0] CP7W   = {OP_CP, 24'h123456};
    localparam logic [31:0] IMM_A  = 32'hDEADBEEF;
    localparam logic [31:0] IMM_B  = 32'hCAFEF00D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance A signals
    logic        startA, jmpA, haltedA;
    logic [9:0]  jaddrA, addrA, pcA;
    logic [31:0] rdataA, instr0A, instr1A;
    logic [3:0]  stateA;
    logic [31:0] memA [0:1023];

    // Instance B signals
    logic        startB, jmpB, haltedB;
    logic [3:0]  jaddrB, addrB, pcB;
    logic [31:0] rdataB, instr0B, instr1B;
    logic [3:0]  stateB;
    logic [31:0] memB [0:15];

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] sbA[$];
    logic [63:0] sbB[$];

    instr_fetch_seq dutA (
        .clk             (clk),
        .reset           (reset),
        .start_i         (startA),
        .pmem_addr_o     (addrA),
        .pmem_rdata_i    (rdataA),
        .jmp_req_i       (jmpA),
        .jmp_addr_i      (jaddrA),
        .instr0_o        (instr0A),
        .instr1_o        (instr1A),
        .current_state_o (stateA),
        .pc_o            (pcA),
        .halted_o        (haltedA)
    );

    instr_fetch_seq #(
        .PMEM_AW  (4),
        .RESET_PC (4'd15)
    ) dutB (
        .clk             (clk),
        .reset           (reset),
        .start_i         (startB),
        .pmem_addr_o     (addrB),
        .pmem_rdata_i    (rdataB),
        .jmp_req_i       (jmpB),
        .jmp_addr_i      (jaddrB),
        .instr0_o        (instr0B),
        .instr1_o        (instr1B),
        .current_state_o (stateB),
        .pc_o            (pcB),
        .halted_o        (haltedB)
    );

    // Synchronous program memories
    always @(posedge clk) rdataA <= memA[addrA];
    always @(posedge clk) rdataB <= memB[addrB];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic [3:0] exp, input string tag);
        @(negedge clk);
        chk_eq(tag, {60'd0, stateA}, {60'd0, exp});
    endtask

    task automatic step_b(input logic [3:0] exp, input string tag);
        @(negedge clk);
        chk_eq(tag, {60'd0, stateB}, {60'd0, exp});
    endtask

    // Scoreboard monitors: every EXEC cycle must match the oldest queued entry
    always @(negedge clk) begin
        if (stateA == STATE_EXEC) begin
            chk_eq("sbA_avail", 64'(sbA.size() != 0), 64'd1);
            if (sbA.size() != 0) begin
                logic [63:0] e;
                e = sbA.pop_front();
                chk_eq("sbA_instr0", {32'd0, instr0A}, {32'd0, e[63:32]});
                chk_eq("sbA_instr1", {32'd0, instr1A}, {32'd0, e[31:0]});
            end
        end
    end

    always @(negedge clk) begin
        if (stateB == STATE_EXEC) begin
            chk_eq("sbB_avail", 64'(sbB.size() != 0), 64'd1);
            if (sbB.size() != 0) begin
                logic [63:0] e;
                e = sbB.pop_front();
                chk_eq("sbB_instr0", {32'd0, instr0B}, {32'd0, e[63:32]});
                chk_eq("sbB_instr1", {32'd0, instr1B}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        reset  = 1'b1;
        startA = 1'b0; jmpA = 1'b0; jaddrA = '0;
        startB = 1'b0; jmpB = 1'b0; jaddrB = '0;
        for (int i = 0; i < 1024; i++) memA[i] = {8'h00, 24'(i)};
        for (int i = 0; i < 16; i++)   memB[i] = {8'h00, 24'(i)};
        memA[0] = CPW;
        memA[1] = ENDW;

        // Reset values
        repeat (2) @(negedge clk);
        chk_eq("rst_state", {60'd0, stateA}, {60'd0, STATE_HLT});
        chk_eq("rst_pc", 64'(pcA), 64'd0);
        chk_eq("rst_addr", 64'(addrA), 64'd0);
        chk_eq("rst_instr0", 64'(instr0A), 64'd0);
        chk_eq("rst_instr1", 64'(instr1A), 64'd0);
        chk_eq("rst_halted", 64'(haltedA), 64'd1);
        chk_eq("rstB_pc", 64'(pcB), 64'd15);
        reset = 1'b0;

        // One-word instruction followed by END
        sbA.push_back({CPW, 32'd0});
        startA = 1'b1;
        step_a(STATE_FETCH0, "p1_fetch0");
        startA = 1'b0;
        chk_eq("p1_addr0", 64'(addrA), 64'd0);
        step_a(STATE_FETCH0_W, "p1_fetch0w");
        step_a(STATE_EXEC, "p1_exec");
        step_a(STATE_FETCH0, "p1_fetch0b");
        chk_eq("p1_pc_after_exec", 64'(pcA), 64'd1);
        step_a(STATE_FETCH0_W, "p1_fetch0w_b");
        step_a(STATE_HLT, "p1_hlt");
        chk_eq("p1_pc_end", 64'(pcA), 64'd2);

        // LIMM32, jump to 7, ignored jump outside EXEC, jump to END at 3
        memA[0] = LIMMW;
        memA[1] = IMM_A;
        memA[2] = ENDW;
        memA[3] = ENDW;
        memA[7] = CP7W;
        sbA.push_back({LIMMW, IMM_A});
        startA = 1'b1;
        step_a(STATE_FETCH0, "p2_fetch0");
        startA = 1'b0;
        chk_eq("p2_addr0", 64'(addrA), 64'd0);
        step_a(STATE_FETCH0_W, "p2_fetch0w");
        step_a(STATE_FETCH1, "p2_fetch1");
        chk_eq("p2_addr1", 64'(addrA), 64'd1);
        chk_eq("p2_instr0", 64'(instr0A), 64'(LIMMW));
        step_a(STATE_FETCH1_W, "p2_fetch1w");
        step_a(STATE_EXEC, "p2_exec");
        chk_eq("p2_pc", 64'(pcA), 64'd2);
        sbA.push_back({CP7W, 32'd0});
        jmpA = 1'b1; jaddrA = 10'd7;
        step_a(STATE_FETCH0, "p3_fetch0");
        jmpA = 1'b0;
        chk_eq("p3_jump_addr", 64'(addrA), 64'd7);
        step_a(STATE_FETCH0_W, "p3_fetch0w");
        jmpA = 1'b1; jaddrA = 10'h55;
        step_a(STATE_EXEC, "p3_exec");
        chk_eq("p3_jmp_ignored_pc", 64'(pcA), 64'd8);
        jaddrA = 10'd3;
        step_a(STATE_FETCH0, "p4_fetch0");
        jmpA = 1'b0;
        chk_eq("p4_addr3", 64'(addrA), 64'd3);
        step_a(STATE_FETCH0_W, "p4_fetch0w");
        step_a(STATE_HLT, "p4_hlt");
        chk_eq("p4_halted", 64'(haltedA), 64'd1);
        chk_eq("p4_pc", 64'(pcA), 64'd4);
        chk_eq("p4_instr0_end", 64'(instr0A), 64'(ENDW));

        // Restart; start during FETCH1 must be ignored
        sbA.push_back({LIMMW, IMM_A});
        startA = 1'b1;
        step_a(STATE_FETCH0, "p4r_fetch0");
        startA = 1'b0;
        chk_eq("p4r_addr0", 64'(addrA), 64'd0);
        step_a(STATE_FETCH0_W, "p4r_fetch0w");
        step_a(STATE_FETCH1, "p4r_fetch1");
        startA = 1'b1;
        step_a(STATE_FETCH1_W, "p4r_start_ignored");
        startA = 1'b0;
        step_a(STATE_EXEC, "p4r_exec");
        step_a(STATE_FETCH0, "p4r_fetch0b");
        chk_eq("p4r_addr2", 64'(addrA), 64'd2);
        step_a(STATE_FETCH0_W, "p4r_fetch0w_b");
        step_a(STATE_HLT, "p4r_hlt");
        chk_eq("p4r_pc", 64'(pcA), 64'd3);

        // Asynchronous reset in the middle of FETCH1_W
        startA = 1'b1;
        step_a(STATE_FETCH0, "p6_fetch0");
        startA = 1'b0;
        step_a(STATE_FETCH0_W, "p6_fetch0w");
        step_a(STATE_FETCH1, "p6_fetch1");
        step_a(STATE_FETCH1_W, "p6_fetch1w");
        #2 reset = 1'b1;
        #1;
        chk_eq("p6_state", {60'd0, stateA}, {60'd0, STATE_HLT});
        chk_eq("p6_instr0", 64'(instr0A), 64'd0);
        chk_eq("p6_instr1", 64'(instr1A), 64'd0);
        chk_eq("p6_addr", 64'(addrA), 64'd0);
        chk_eq("p6_halted", 64'(haltedA), 64'd1);
        @(negedge clk);
        startA = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        startA = 1'b0;
        step_a(STATE_HLT, "p6_reset_wins");

        // Instance B: LIMM32 at last address wraps, then jump to current PC
        memB[15] = LIMMW;
        memB[0]  = IMM_B;
        memB[1]  = ENDW;
        sbB.push_back({LIMMW, IMM_B});
        startB = 1'b1;
        step_b(STATE_FETCH0, "p5_fetch0");
        startB = 1'b0;
        chk_eq("p5_addr15", 64'(addrB), 64'd15);
        step_b(STATE_FETCH0_W, "p5_fetch0w");
        step_b(STATE_FETCH1, "p5_fetch1");
        chk_eq("p5_wrap_addr0", 64'(addrB), 64'd0);
        step_b(STATE_FETCH1_W, "p5_fetch1w");
        step_b(STATE_EXEC, "p5_exec");
        chk_eq("p5_pc1", 64'(pcB), 64'd1);
        jmpB = 1'b1; jaddrB = 4'd1;
        step_b(STATE_FETCH0, "p5_self_jump");
        jmpB = 1'b0;
        chk_eq("p5_self_jump_addr", 64'(addrB), 64'd1);
        step_b(STATE_FETCH0_W, "p5_fetch0w_b");
        step_b(STATE_HLT, "p5_hlt");
        chk_eq("p5_pc_end", 64'(pcB), 64'd2);

        @(negedge clk);
        chk_eq("sbA_drained", 64'(sbA.size()), 64'd0);
        chk_eq("sbB_drained", 64'(sbB.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_instr_fetch_seq
`default_nettype wire
